// File: rtl/conn_setup_sequencer.sv
// Connection-setup sequencer: queues open/close descriptors and serializes each one
// into the RPC unit's per-field setup command stream, then reports one completion.
module conn_setup_sequencer #(
    parameter int NIC_ID         = 0,
    parameter int QDEPTH         = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SETUP_CMD_W    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   initialized_in,
    input  logic                   req_valid_in,
    output logic                   req_ready_out,
    input  logic                   req_open_in,
    input  logic [31:0]            req_conn_id_in,
    input  logic [31:0]            req_dest_ip_in,
    input  logic [15:0]            req_dest_port_in,
    input  logic [15:0]            req_client_flow_id_in,
    output logic                   setup_en_out,
    output logic [SETUP_CMD_W-1:0] setup_cmd_out,
    output logic [31:0]            setup_data_out,
    input  logic                   cm_status_valid_in,
    input  logic                   cm_status_error_in,
    output logic                   done_valid_out,
    output logic [31:0]            done_conn_id_out,
    output logic [1:0]             done_code_out,
    output logic                   busy_out,
    output logic                   error_out
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   QFULL   = QDEPTH[AW:0];
    localparam logic [CW-1:0] TMO_MAX = TIMEOUT_CYCLES[CW-1:0];

    localparam logic [SETUP_CMD_W-1:0] SET_UP_CONN_ID        = 0;
    localparam logic [SETUP_CMD_W-1:0] SET_UP_OPEN           = 1;
    localparam logic [SETUP_CMD_W-1:0] SET_UP_DEST_IPV4      = 2;
    localparam logic [SETUP_CMD_W-1:0] SET_UP_DEST_PORT      = 3;
    localparam logic [SETUP_CMD_W-1:0] SET_UP_CLIENT_FLOW_ID = 4;
    localparam logic [SETUP_CMD_W-1:0] SET_UP_ENABLE         = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_REPORT} state_t;

    state_t state_q, state_d;

    // Descriptor queue storage; only the pointers and occupancy are reset.
    logic        q_open [QDEPTH];
    logic [31:0] q_conn [QDEPTH];
    logic [31:0] q_ip   [QDEPTH];
    logic [15:0] q_port [QDEPTH];
    logic [15:0] q_flow [QDEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop;

    logic        desc_open_q;
    logic [31:0] desc_conn_q, desc_ip_q;
    logic [15:0] desc_port_q, desc_flow_q;

    logic [2:0]    idx_q, idx_d, nframes, field;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [1:0]    code_q, code_d;
    logic          err_q;

    logic                   en_q, en_d;
    logic [SETUP_CMD_W-1:0] cmd_q, cmd_d;
    logic [31:0]            data_q, data_d;

    assign push    = req_valid_in && req_ready_out;
    assign nframes = desc_open_q ? 3'd6 : 3'd3;
    // A close descriptor skips the address fields: its third frame is Enable.
    assign field   = (!desc_open_q && idx_q == 3'd2) ? 3'd5 : idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        code_d  = code_q;
        pop     = 1'b0;
        en_d    = 1'b0;
        cmd_d   = '0;
        data_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0 && initialized_in) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (idx_q == nframes) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    en_d  = 1'b1;
                    idx_d = idx_q + 3'd1;
                    case (field)
                        3'd0: begin cmd_d = SET_UP_CONN_ID;        data_d = desc_conn_q; end
                        3'd1: begin cmd_d = SET_UP_OPEN;           data_d = {31'b0, desc_open_q}; end
                        3'd2: begin cmd_d = SET_UP_DEST_IPV4;      data_d = desc_ip_q; end
                        3'd3: begin cmd_d = SET_UP_DEST_PORT;      data_d = {16'b0, desc_port_q}; end
                        3'd4: begin cmd_d = SET_UP_CLIENT_FLOW_ID; data_d = {16'b0, desc_flow_q}; end
                        default: begin cmd_d = SET_UP_ENABLE;      data_d = 32'd1; end
                    endcase
                end
            end
            ST_WAIT: begin
                // Status takes priority over an expiry in the same cycle.
                if (cm_status_valid_in) begin
                    code_d  = cm_status_error_in ? 2'd1 : 2'd0;
                    state_d = ST_REPORT;
                end else if (tmo_q == TMO_MAX) begin
                    code_d  = 2'd2;
                    state_d = ST_REPORT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            desc_open_q <= 1'b0;
            desc_conn_q <= '0;
            desc_ip_q   <= '0;
            desc_port_q <= '0;
            desc_flow_q <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            code_q      <= '0;
            err_q       <= 1'b0;
            en_q        <= 1'b0;
            cmd_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            en_q    <= en_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                desc_open_q <= q_open[rd_ptr_q];
                desc_conn_q <= q_conn[rd_ptr_q];
                desc_ip_q   <= q_ip[rd_ptr_q];
                desc_port_q <= q_port[rd_ptr_q];
                desc_flow_q <= q_flow[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (cm_status_valid_in && state_q != ST_WAIT) begin
                err_q <= 1'b1;
`ifndef SYNTHESIS
                $display("conn_setup_sequencer[%0d]: status strobe outside WAIT ignored", NIC_ID);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_open[wr_ptr_q] <= req_open_in;
            q_conn[wr_ptr_q] <= req_conn_id_in;
            q_ip[wr_ptr_q]   <= req_dest_ip_in;
            q_port[wr_ptr_q] <= req_dest_port_in;
            q_flow[wr_ptr_q] <= req_client_flow_id_in;
        end
    end

    assign req_ready_out    = (count_q != QFULL);
    assign busy_out         = (state_q != ST_IDLE) || (count_q != '0);
    assign error_out        = err_q;
    assign setup_en_out     = en_q;
    assign setup_cmd_out    = cmd_q;
    assign setup_data_out   = data_q;
    assign done_valid_out   = (state_q == ST_REPORT);
    assign done_conn_id_out = (state_q == ST_REPORT) ? desc_conn_q : 32'd0;
    assign done_code_out    = (state_q == ST_REPORT) ? code_q : 2'd0;

endmodule

// File: tb/tb_conn_setup_sequencer.sv
// Directed bench for conn_setup_sequencer: vector table of descriptors plus
// hand-written sequences for gating, queue-full, spurious status and reset.
`timescale 1ns/1ps
module tb_conn_setup_sequencer;

    localparam int QDEPTH = 4;
    localparam int TMO    = 8;
    localparam int CMDW   = 3;
    localparam logic [CMDW-1:0] C_CONN = 0, C_OPEN = 1, C_IP = 2, C_PORT = 3, C_FLOW = 4, C_EN = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            initialized_in;
    logic            req_valid_in;
    logic            req_ready_out;
    logic            req_open_in;
    logic [31:0]     req_conn_id_in;
    logic [31:0]     req_dest_ip_in;
    logic [15:0]     req_dest_port_in;
    logic [15:0]     req_client_flow_id_in;
    logic            setup_en_out;
    logic [CMDW-1:0] setup_cmd_out;
    logic [31:0]     setup_data_out;
    logic            cm_status_valid_in;
    logic            cm_status_error_in;
    logic            done_valid_out;
    logic [31:0]     done_conn_id_out;
    logic [1:0]      done_code_out;
    logic            busy_out;
    logic            error_out;

    conn_setup_sequencer #(
        .NIC_ID(3), .QDEPTH(QDEPTH), .TIMEOUT_CYCLES(TMO), .SETUP_CMD_W(CMDW)
    ) dut (
        .clk(clk), .reset(reset), .initialized_in(initialized_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_open_in(req_open_in), .req_conn_id_in(req_conn_id_in),
        .req_dest_ip_in(req_dest_ip_in), .req_dest_port_in(req_dest_port_in),
        .req_client_flow_id_in(req_client_flow_id_in),
        .setup_en_out(setup_en_out), .setup_cmd_out(setup_cmd_out),
        .setup_data_out(setup_data_out),
        .cm_status_valid_in(cm_status_valid_in), .cm_status_error_in(cm_status_error_in),
        .done_valid_out(done_valid_out), .done_conn_id_out(done_conn_id_out),
        .done_code_out(done_code_out), .busy_out(busy_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CMDW+31:0] exp_q[$];

    typedef struct {
        logic        op;
        logic [31:0] conn;
        logic [31:0] ip;
        logic [15:0] port;
        logic [15:0] flow;
        int          k;      // WAIT cycle carrying the status, 0 = none
        logic        err;
        logic [1:0]  code;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frames(input logic op, input logic [31:0] conn, input logic [31:0] ip,
                                input logic [15:0] port, input logic [15:0] flow);
        exp_q.push_back({C_CONN, conn});
        exp_q.push_back({C_OPEN, {31'b0, op}});
        if (op) begin
            exp_q.push_back({C_IP, ip});
            exp_q.push_back({C_PORT, {16'b0, port}});
            exp_q.push_back({C_FLOW, {16'b0, flow}});
        end
        exp_q.push_back({C_EN, 32'd1});
    endtask

    // Checks n consecutive frames; the first must be visible in the current cycle.
    task automatic check_frames(input int n);
        logic [CMDW+31:0] e;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            e = exp_q.pop_front();
            chk("frame_en", setup_en_out, 1);
            chk("frame_cmd", setup_cmd_out, e[CMDW+31:32]);
            chk("frame_data", setup_data_out, e[31:0]);
        end
    endtask

    task automatic wait_frame(input int budget);
        int w;
        w = 0;
        step();
        while (!setup_en_out && w < budget) begin
            step();
            w++;
        end
        chk("frame_start", setup_en_out, 1);
    endtask

    // Called in the Enable cycle; walks WAIT and checks the completion.
    task automatic wait_done(input int k, input logic err, input logic [31:0] conn, input logic [1:0] code);
        int last;
        last = (k == 0) ? TMO + 1 : k;
        for (int c = 1; c <= last; c++) begin
            step();
            chk("wait_en", setup_en_out, 0);
            chk("wait_done_early", done_valid_out, 0);
            if (c == k) begin
                cm_status_valid_in = 1'b1;
                cm_status_error_in = err;
            end
        end
        step();
        cm_status_valid_in = 1'b0;
        cm_status_error_in = 1'b0;
        chk("done_valid", done_valid_out, 1);
        chk("done_conn", done_conn_id_out, conn);
        chk("done_code", done_code_out, code);
    endtask

    task automatic push(input logic op, input logic [31:0] conn, input logic [31:0] ip,
                        input logic [15:0] port, input logic [15:0] flow);
        int w;
        w = 0;
        while (!req_ready_out && w < 200) begin
            step();
            w++;
        end
        chk("push_ready", req_ready_out, 1);
        req_valid_in          = 1'b1;
        req_open_in           = op;
        req_conn_id_in        = conn;
        req_dest_ip_in        = ip;
        req_dest_port_in      = port;
        req_client_flow_id_in = flow;
        step();
        req_valid_in = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'd5,          32'h0A000001, 16'd80,     16'd3,      3, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 32'd9,          32'h0,        16'd0,      16'd0,      2, 1'b1, 2'd1};
        vecs[2] = '{1'b1, 32'h12345678,   32'hC0A80101, 16'hFFFF,   16'hBEEF,   0, 1'b0, 2'd2};
        vecs[3] = '{1'b0, 32'hDEADBEEF,   32'h0,        16'd0,      16'd0,      TMO + 1, 1'b0, 2'd0};
        vecs[4] = '{1'b1, 32'h00000001,   32'hFFFFFFFF, 16'h0001,   16'h8000,   1, 1'b1, 2'd1};
        vecs[5] = '{1'b0, 32'h80000000,   32'h0,        16'd0,      16'd0,      TMO + 1, 1'b1, 2'd1};

        reset = 1'b1;
        initialized_in = 1'b1;
        req_valid_in = 1'b0;
        req_open_in = 1'b0;
        req_conn_id_in = '0;
        req_dest_ip_in = '0;
        req_dest_port_in = '0;
        req_client_flow_id_in = '0;
        cm_status_valid_in = 1'b0;
        cm_status_error_in = 1'b0;
        step();
        step();
        chk("rst_en", setup_en_out, 0);
        chk("rst_cmd", setup_cmd_out, 0);
        chk("rst_data", setup_data_out, 0);
        chk("rst_done", done_valid_out, 0);
        chk("rst_done_conn", done_conn_id_out, 0);
        chk("rst_done_code", done_code_out, 0);
        chk("rst_error", error_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", req_ready_out, 1);
        reset = 1'b0;
        step();

        // Table: exact accept-to-frame latency, frame order, status/timeout codes.
        for (int v = 0; v < 6; v++) begin
            push(vecs[v].op, vecs[v].conn, vecs[v].ip, vecs[v].port, vecs[v].flow);
            build_frames(vecs[v].op, vecs[v].conn, vecs[v].ip, vecs[v].port, vecs[v].flow);
            step();
            chk("pop_cycle_en", setup_en_out, 0);
            step();
            check_frames(vecs[v].op ? 6 : 3);
            wait_done(vecs[v].k, vecs[v].err, vecs[v].conn, vecs[v].code);
            step();
            chk("done_one_cycle", done_valid_out, 0);
            chk("idle_busy", busy_out, 0);
        end

        // Status outside WAIT after the timeouts above.
        chk("error_clean", error_out, 0);
        cm_status_valid_in = 1'b1;
        step();
        cm_status_valid_in = 1'b0;
        chk("spurious_error", error_out, 1);
        chk("spurious_no_done", done_valid_out, 0);
        step();
        step();
        chk("error_sticky", error_out, 1);
        chk("spurious_no_frame", setup_en_out, 0);

        // Gating on initialized_in; dropping it mid-sequence does not abort.
        initialized_in = 1'b0;
        push(1'b0, 32'h77, 32'h0, 16'h0, 16'h0);
        build_frames(1'b0, 32'h77, 32'h0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("gated_en", setup_en_out, 0);
            chk("gated_busy", busy_out, 1);
        end
        initialized_in = 1'b1;
        step();
        chk("ungate_pop_en", setup_en_out, 0);
        step();
        initialized_in = 1'b0;
        check_frames(3);
        wait_done(4, 1'b0, 32'h77, 2'd0);
        initialized_in = 1'b1;
        step();

        // Queue full: first descriptor popped while four more are queued.
        for (int j = 0; j < 5; j++)
            build_frames(j[0], 32'd100 + j, 32'hA0000000 + j, 16'd1000 + 16'(j), 16'd7 + 16'(j));
        fork
            begin
                for (int j = 0; j < 4; j++)
                    push(j[0], 32'd100 + j, 32'hA0000000 + j, 16'd1000 + 16'(j), 16'd7 + 16'(j));
                chk("ready_before_full", req_ready_out, 1);
                push(1'b0, 32'd104, 32'hA0000004, 16'd1004, 16'd11);
                chk("ready_when_full", req_ready_out, 0);
                chk("busy_when_full", busy_out, 1);
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    wait_frame(30);
                    check_frames(j[0] ? 6 : 3);
                    wait_done(0, 1'b0, 32'd100 + j, 2'd2);
                end
            end
        join
        step();
        chk("drained_busy", busy_out, 0);
        chk("drained_ready", req_ready_out, 1);

        // Reset after the third frame flushes the queue and reports nothing.
        push(1'b1, 32'h42, 32'h01020304, 16'd443, 16'd9);
        build_frames(1'b1, 32'h42, 32'h01020304, 16'd443, 16'd9);
        push(1'b0, 32'h43, 32'h0, 16'h0, 16'h0);
        step();
        check_frames(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("rst_mid_en", setup_en_out, 0);
        chk("rst_mid_cmd", setup_cmd_out, 0);
        chk("rst_mid_busy", busy_out, 0);
        chk("rst_mid_done", done_valid_out, 0);
        chk("rst_mid_ready", req_ready_out, 1);
        chk("rst_mid_error", error_out, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rst_en", setup_en_out, 0);
            chk("post_rst_done", done_valid_out, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
